// File: rtl/buffer_register_sequencer_pkg.sv
// Shared types and constants for the buffer-register sequencer.
package buffer_register_sequencer_pkg;

  localparam int unsigned MOD_W = 3;
  localparam int unsigned MSA_W = 8;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_SENSE = 3'd2,
    ST_SBRX  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef enum logic {
    OP_READ = 1'b0,
    OP_XFER = 1'b1
  } op_t;

  // Registered output bundle; index 0 is side A1, index 1 is side A2.
  typedef struct packed {
    logic [1:0]       cbrvn;
    logic [1:0]       sbrxv;
    logic [1:0]       parv;
    logic [MSA_W-1:0] msa_sel;
    logic             rd_ack;
    logic             xf_ack;
    logic             busy;
  } seq_out_t;

  localparam seq_out_t OUT_RST = '{
    cbrvn:   2'b11,
    sbrxv:   2'b00,
    parv:    2'b00,
    msa_sel: 8'h00,
    rd_ack:  1'b0,
    xf_ack:  1'b0,
    busy:    1'b0
  };

  // Even modules sit on side A1, odd modules on side A2.
  function automatic logic side_of(input logic [MOD_W-1:0] mod);
    return mod[0];
  endfunction

endpackage

// File: rtl/buffer_register_sequencer_bitcount_mod8.sv
// 3-bit bit-time counter for the serial-transfer phase.
module bitcount_mod8
  import buffer_register_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count,
  output logic [CNT_W-1:0] o_count_nxt_c
);

  logic [CNT_W-1:0] r_count;

  // Next count: clear wins over increment, wraps modulo 8.
  always_comb begin
    o_count_nxt_c = r_count;
    if (i_clear) begin
      o_count_nxt_c = '0;
    end else if (i_inc) begin
      o_count_nxt_c = r_count + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      r_count <= o_count_nxt_c;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/buffer_register_sequencer.sv
// Sequences buffer-register clear, sense-amp strobe and serial transfer
// for memory reads and serial transfers, stepping once per v1 bit-time.
module buffer_register_sequencer
  import buffer_register_sequencer_pkg::*;
#(
  parameter int unsigned SBRX_LEN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             v1,
  input  logic             rd_req,
  input  logic [MOD_W-1:0] rd_mod,
  output logic             rd_ack,
  input  logic             xf_req,
  input  logic             xf_side,
  output logic             xf_ack,
  output logic             a1cbrvn,
  output logic             a2cbrvn,
  output logic             a1sbrxv,
  output logic             a2sbrxv,
  output logic             a1parv,
  output logic             a2parv,
  output logic [MSA_W-1:0] msa_sel,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SBRX_LEN - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  op_t              r_op;
  op_t              w_op_nxt;
  logic             r_side;
  logic             w_side_nxt;
  logic [MOD_W-1:0] r_mod;
  logic [MOD_W-1:0] w_mod_nxt;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_cnt_clear;
  logic             w_cnt_inc;
  logic             w_last_bit;
  seq_out_t         r_out;
  seq_out_t         w_out_nxt;

  bitcount_mod8 u_bitcount (
    .clk           (clk),
    .rst           (rst),
    .i_clear       (w_cnt_clear),
    .i_inc         (w_cnt_inc),
    .o_count       (w_count),
    .o_count_nxt_c (w_count_nxt)
  );

  assign w_last_bit = (w_count == LAST_CNT);

  // Next-state, request latching and counter control.
  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_side_nxt  = r_side;
    w_mod_nxt   = r_mod;
    w_cnt_clear = 1'b0;
    w_cnt_inc   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (v1) begin
          if (rd_req) begin
            w_op_nxt    = OP_READ;
            w_mod_nxt   = rd_mod;
            w_side_nxt  = side_of(rd_mod);
            w_state_nxt = ST_CLR;
          end else if (xf_req) begin
            w_op_nxt    = OP_XFER;
            w_side_nxt  = xf_side;
            w_state_nxt = ST_CLR;
          end
        end
      end
      ST_CLR: begin
        if (v1) begin
          if (r_op == OP_READ) begin
            w_state_nxt = ST_SENSE;
          end else begin
            w_state_nxt = ST_SBRX;
            w_cnt_clear = 1'b1;
          end
        end
      end
      ST_SENSE: begin
        if (v1) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_SBRX: begin
        if (v1) begin
          if (w_last_bit) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so registered outputs line up with it.
  always_comb begin
    w_out_nxt      = OUT_RST;
    w_out_nxt.busy = (w_state_nxt != ST_IDLE);
    case (w_state_nxt)
      ST_CLR: begin
        w_out_nxt.cbrvn[w_side_nxt] = 1'b0;
      end
      ST_SENSE: begin
        w_out_nxt.msa_sel = MSA_W'(1) << w_mod_nxt;
      end
      ST_SBRX: begin
        w_out_nxt.sbrxv[w_side_nxt] = 1'b1;
        w_out_nxt.parv[w_side_nxt]  = (w_count_nxt == LAST_CNT);
      end
      ST_DONE: begin
        w_out_nxt.rd_ack = (w_op_nxt == OP_READ);
        w_out_nxt.xf_ack = (w_op_nxt == OP_XFER);
      end
      default: begin
        w_out_nxt.busy = w_out_nxt.busy;
      end
    endcase
  end

  // State, latch and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op    <= OP_READ;
      r_side  <= 1'b0;
      r_mod   <= '0;
      r_out   <= OUT_RST;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_side  <= w_side_nxt;
      r_mod   <= w_mod_nxt;
      r_out   <= w_out_nxt;
    end
  end

  assign a1cbrvn = r_out.cbrvn[0];
  assign a2cbrvn = r_out.cbrvn[1];
  assign a1sbrxv = r_out.sbrxv[0];
  assign a2sbrxv = r_out.sbrxv[1];
  assign a1parv  = r_out.parv[0];
  assign a2parv  = r_out.parv[1];
  assign msa_sel = r_out.msa_sel;
  assign rd_ack  = r_out.rd_ack;
  assign xf_ack  = r_out.xf_ack;
  assign busy    = r_out.busy;

endmodule

// File: tb/tb_buffer_register_sequencer.sv
// Bench for buffer_register_sequencer: two instances (SBRX_LEN 2 and 7)
// share stimulus; a bit-time level model is checked every clock, plus
// table-driven transactions and directed corner sequences.
module tb_buffer_register_sequencer;

  typedef struct packed {
    logic       c1, c2, s1, s2, p1, p2;
    logic [7:0] msa;
    logic       rda, xfa, busy;
  } obs_t;

  typedef struct {
    bit active;
    bit done;
    bit xf;
    bit side;
    int p;
    int mod;
  } mdl_t;

  typedef struct {
    int dut;
    int is_xf;
    int side;
    int mod;
    int exp_clr;
    int exp_msa;
    int exp_msa_clks;
    int exp_sbrx;
    int exp_par;
    int exp_par_start;
    int exp_busy;
    int exp_rda;
    int exp_xfa;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       v1;
  logic       rd_req;
  logic [2:0] rd_mod;
  logic       xf_req;
  logic       xf_side;

  logic       a1c_2, a2c_2, a1s_2, a2s_2, a1p_2, a2p_2, rda_2, xfa_2, busy_2;
  logic [7:0] msa_2;
  logic       a1c_7, a2c_7, a1s_7, a2s_7, a1p_7, a2p_7, rda_7, xfa_7, busy_7;
  logic [7:0] msa_7;
  obs_t       obs2, obs7;

  int   checks = 0;
  int   errors = 0;
  mdl_t m2, m7;
  int   v1_per = 4;
  bit   v1_en = 1'b1;
  bit   v1_rand = 1'b0;
  int   vcnt = 0;

  buffer_register_sequencer #(.SBRX_LEN(2)) dut2 (
    .clk(clk), .rst(rst), .v1(v1), .rd_req(rd_req), .rd_mod(rd_mod), .rd_ack(rda_2),
    .xf_req(xf_req), .xf_side(xf_side), .xf_ack(xfa_2),
    .a1cbrvn(a1c_2), .a2cbrvn(a2c_2), .a1sbrxv(a1s_2), .a2sbrxv(a2s_2),
    .a1parv(a1p_2), .a2parv(a2p_2), .msa_sel(msa_2), .busy(busy_2)
  );

  buffer_register_sequencer #(.SBRX_LEN(7)) dut7 (
    .clk(clk), .rst(rst), .v1(v1), .rd_req(rd_req), .rd_mod(rd_mod), .rd_ack(rda_7),
    .xf_req(xf_req), .xf_side(xf_side), .xf_ack(xfa_7),
    .a1cbrvn(a1c_7), .a2cbrvn(a2c_7), .a1sbrxv(a1s_7), .a2sbrxv(a2s_7),
    .a1parv(a1p_7), .a2parv(a2p_7), .msa_sel(msa_7), .busy(busy_7)
  );

  assign obs2 = {a1c_2, a2c_2, a1s_2, a2s_2, a1p_2, a2p_2, msa_2, rda_2, xfa_2, busy_2};
  assign obs7 = {a1c_7, a2c_7, a1s_7, a2s_7, a1p_7, a2p_7, msa_7, rda_7, xfa_7, busy_7};

  always #5 clk = ~clk;

  function automatic obs_t get_obs(int d);
    return (d == 7) ? obs7 : obs2;
  endfunction

  function automatic mdl_t mdl_clear();
    mdl_t m;
    m.active = 1'b0; m.done = 1'b0; m.xf = 1'b0; m.side = 1'b0; m.p = 0; m.mod = 0;
    return m;
  endfunction

  // Expected outputs from the bit-time position inside the current operation.
  function automatic obs_t expect_of(mdl_t m, int len);
    obs_t e;
    e = '0;
    e.c1 = 1'b1;
    e.c2 = 1'b1;
    if (m.done) begin
      e.busy = 1'b1;
      if (m.xf) e.xfa = 1'b1; else e.rda = 1'b1;
    end else if (m.active) begin
      e.busy = 1'b1;
      if (m.p == 0) begin
        if (m.side) e.c2 = 1'b0; else e.c1 = 1'b0;
      end else if (!m.xf) begin
        e.msa = 8'(1) << m.mod;
      end else begin
        if (m.side) e.s2 = 1'b1; else e.s1 = 1'b1;
        if (m.p == len) begin
          if (m.side) e.p2 = 1'b1; else e.p1 = 1'b1;
        end
      end
    end
    return e;
  endfunction

  // One clock of the model: an operation spans 2 (read) or 1+len (transfer)
  // bit-times after grant, then one acknowledge clock.
  function automatic mdl_t step(mdl_t m, bit v, bit rq, logic [2:0] md, bit xq, bit xs, int len);
    mdl_t n;
    n = m;
    if (m.done) begin
      n.done = 1'b0;
    end else if (m.active) begin
      if (v) begin
        n.p = m.p + 1;
        if (n.p == (m.xf ? 1 + len : 2)) begin
          n.active = 1'b0;
          n.done   = 1'b1;
        end
      end
    end else if (v && rq) begin
      n.active = 1'b1; n.xf = 1'b0; n.mod = int'(md); n.side = md[0]; n.p = 0;
    end else if (v && xq) begin
      n.active = 1'b1; n.xf = 1'b1; n.side = xs; n.p = 0;
    end
    return n;
  endfunction

  task automatic check_obs(string name, obs_t act, obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%b expected=%b", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  // Drive v1 at the falling edge, step models at the rising edge, compare 1 time unit later.
  task automatic clk_cycle();
    @(negedge clk);
    if (v1_rand) v1 = ($urandom_range(2, 0) == 0);
    else         v1 = v1_en && ((vcnt % v1_per) == 0);
    vcnt++;
    @(posedge clk);
    if (rst) begin
      m2 = mdl_clear();
      m7 = mdl_clear();
    end else begin
      m2 = step(m2, v1, rd_req, rd_mod, xf_req, xf_side, 2);
      m7 = step(m7, v1, rd_req, rd_mod, xf_req, xf_side, 7);
    end
    #1;
    check_obs("model_len2", obs2, expect_of(m2, 2));
    check_obs("model_len7", obs7, expect_of(m7, 7));
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((obs2.busy || obs7.busy) && guard < 300) begin
      clk_cycle();
      if (obs2.rda || obs7.rda) rd_req = 1'b0;
      if (obs2.xfa || obs7.xfa) xf_req = 1'b0;
      guard++;
    end
    if (guard >= 300) chk_int("idle_timeout", guard, 0);
  endtask

  task automatic run_vec(int idx, vec_t v);
    int   clr, wrong, msa_clks, msa, sbrx, par, par_start, busy_clks, rda, xfa, guard;
    bit   seen_busy, finished;
    bit   own_c, own_s, own_p, oth_c, oth_s, oth_p;
    obs_t o;
    clr = 0; wrong = 0; msa_clks = 0; msa = 0; sbrx = 0; par = 0; par_start = -1;
    busy_clks = 0; rda = 0; xfa = 0; guard = 0; seen_busy = 1'b0; finished = 1'b0;
    wait_idle();
    if (v.is_xf != 0) begin
      xf_side = v.side[0];
      xf_req  = 1'b1;
    end else begin
      rd_mod = 3'(v.mod);
      rd_req = 1'b1;
    end
    while (!finished && guard < 400) begin
      clk_cycle();
      guard++;
      o = get_obs(v.dut);
      own_c = v.side[0] ? o.c2 : o.c1;
      own_s = v.side[0] ? o.s2 : o.s1;
      own_p = v.side[0] ? o.p2 : o.p1;
      oth_c = v.side[0] ? o.c1 : o.c2;
      oth_s = v.side[0] ? o.s1 : o.s2;
      oth_p = v.side[0] ? o.p1 : o.p2;
      if (!own_c) clr++;
      if (!oth_c || oth_s || oth_p) wrong++;
      if (o.msa != 8'h00) begin
        msa_clks++;
        msa = msa | int'(o.msa);
      end
      if (own_s) begin
        if (own_p && par_start < 0) par_start = sbrx;
        sbrx++;
      end
      if (own_p) par++;
      if (o.busy) begin
        busy_clks++;
        seen_busy = 1'b1;
      end else if (seen_busy) begin
        finished = 1'b1;
      end
      if (o.rda) rda++;
      if (o.xfa) xfa++;
      if (obs2.rda || obs7.rda) rd_req = 1'b0;
      if (obs2.xfa || obs7.xfa) xf_req = 1'b0;
    end
    if (!finished) chk_int($sformatf("vec%0d_timeout", idx), 0, 1);
    chk_int($sformatf("vec%0d_clr_clks", idx), clr, v.exp_clr);
    chk_int($sformatf("vec%0d_other_side", idx), wrong, 0);
    chk_int($sformatf("vec%0d_msa", idx), msa, v.exp_msa);
    chk_int($sformatf("vec%0d_msa_clks", idx), msa_clks, v.exp_msa_clks);
    chk_int($sformatf("vec%0d_sbrx_clks", idx), sbrx, v.exp_sbrx);
    chk_int($sformatf("vec%0d_par_clks", idx), par, v.exp_par);
    chk_int($sformatf("vec%0d_par_start", idx), par_start, v.exp_par_start);
    chk_int($sformatf("vec%0d_busy_clks", idx), busy_clks, v.exp_busy);
    chk_int($sformatf("vec%0d_rd_ack", idx), rda, v.exp_rda);
    chk_int($sformatf("vec%0d_xf_ack", idx), xfa, v.exp_xfa);
  endtask

  initial begin
    vec_t vecs[8];
    obs_t o, ref2, ref7, rst_obs;
    int   guard, chg, msa_first, gap, xfa, ackn;
    bit   sb_early, rd_done, xf_granted;

    // dut, xf, side, mod, clr, msa, msa_clks, sbrx, par, par_start, busy, rda, xfa (v1 every 4 clk)
    vecs[0] = '{2, 0, 1, 5, 4, 32'h20, 4,  0, 0, -1,  9, 1, 0};
    vecs[1] = '{7, 0, 0, 2, 4, 32'h04, 4,  0, 0, -1,  9, 1, 0};
    vecs[2] = '{2, 1, 0, 0, 4, 0,      0,  8, 4,  4, 13, 0, 1};
    vecs[3] = '{7, 1, 1, 0, 4, 0,      0, 28, 4, 24, 33, 0, 1};
    vecs[4] = '{2, 0, 0, 0, 4, 32'h01, 4,  0, 0, -1,  9, 1, 0};
    vecs[5] = '{2, 1, 1, 0, 4, 0,      0,  8, 4,  4, 13, 0, 1};
    vecs[6] = '{7, 0, 1, 7, 4, 32'h80, 4,  0, 0, -1,  9, 1, 0};
    vecs[7] = '{7, 1, 0, 0, 4, 0,      0, 28, 4, 24, 33, 0, 1};

    rst_obs = '0;
    rst_obs.c1 = 1'b1;
    rst_obs.c2 = 1'b1;

    rst = 1'b1; v1 = 1'b0; rd_req = 1'b0; rd_mod = 3'd0; xf_req = 1'b0; xf_side = 1'b0;
    m2 = mdl_clear();
    m7 = mdl_clear();
    clk_cycle();
    clk_cycle();
    check_obs("reset_len2", obs2, rst_obs);
    check_obs("reset_len7", obs7, rst_obs);
    rst = 1'b0;
    clk_cycle();

    // Table-driven transactions.
    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Read and transfer requested on the same v1: read first, transfer on first v1 after IDLE.
    wait_idle();
    rd_mod = 3'd2; rd_req = 1'b1; xf_side = 1'b0; xf_req = 1'b1;
    msa_first = 0; sb_early = 1'b0; rd_done = 1'b0; gap = 0; xf_granted = 1'b0; xfa = 0; guard = 0;
    while (xfa == 0 && guard < 300) begin
      clk_cycle();
      guard++;
      o = obs2;
      if (!rd_done) begin
        if (o.s1 || o.s2) sb_early = 1'b1;
        if (o.msa != 8'h00 && msa_first == 0) msa_first = int'(o.msa);
        if (o.rda) begin
          rd_done = 1'b1;
          rd_req  = 1'b0;
        end
      end else if (!xf_granted) begin
        if (o.busy) xf_granted = 1'b1;
        else gap++;
      end
      if (o.xfa) begin
        xfa++;
        xf_req = 1'b0;
      end
    end
    chk_int("arb_read_msa", msa_first, 4);
    chk_int("arb_no_early_sbrx", int'(sb_early), 0);
    chk_int("arb_idle_gap", gap, 3);
    chk_int("arb_xf_ack", xfa, 1);
    wait_idle();

    // Reset pulsed in the middle of the serial transfer.
    xf_side = 1'b0; xf_req = 1'b1; guard = 0;
    while (!obs2.s1 && guard < 100) begin
      clk_cycle();
      guard++;
    end
    chk_int("rst_reach_sbrx", int'(obs2.s1), 1);
    clk_cycle();
    #2;
    rst = 1'b1;
    xf_req = 1'b0;
    #1;
    m2 = mdl_clear();
    m7 = mdl_clear();
    check_obs("rst_async_len2", obs2, rst_obs);
    check_obs("rst_async_len7", obs7, rst_obs);
    clk_cycle();
    clk_cycle();
    rst = 1'b0;
    ackn = 0;
    for (int i = 0; i < 16; i++) begin
      clk_cycle();
      if (obs2.xfa || obs7.xfa || obs2.busy || obs7.busy) ackn++;
    end
    chk_int("rst_no_ack_no_busy", ackn, 0);

    // v1 held low with a request pending, idle and mid-sequence.
    v1_en = 1'b0; rd_mod = 3'd3; rd_req = 1'b1;
    clk_cycle();
    ref2 = obs2; ref7 = obs7; chg = 0;
    for (int i = 0; i < 20; i++) begin
      clk_cycle();
      if (obs2 !== ref2 || obs7 !== ref7) chg++;
    end
    chk_int("v1low_idle_changes", chg, 0);
    chk_int("v1low_idle_busy", int'(obs2.busy), 0);
    v1_en = 1'b1; guard = 0;
    while (obs2.c2 && guard < 50) begin
      clk_cycle();
      guard++;
    end
    chk_int("v1low_reach_clr", int'(obs2.c2), 0);
    v1_en = 1'b0;
    clk_cycle();
    ref2 = obs2; ref7 = obs7; chg = 0;
    for (int i = 0; i < 20; i++) begin
      clk_cycle();
      if (obs2 !== ref2 || obs7 !== ref7) chg++;
    end
    chk_int("v1low_clr_changes", chg, 0);
    v1_en = 1'b1;
    wait_idle();

    // Randomized requesters and v1 against the model.
    v1_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      clk_cycle();
      if (obs2.rda || obs7.rda) begin
        rd_req = 1'b0;
      end else if (!rd_req) begin
        if ($urandom_range(4, 0) == 0) begin
          rd_req = 1'b1;
          rd_mod = 3'($urandom_range(7, 0));
        end
      end else if ($urandom_range(29, 0) == 0) begin
        rd_req = 1'b0;
      end
      if (obs2.xfa || obs7.xfa) begin
        xf_req = 1'b0;
      end else if (!xf_req) begin
        if ($urandom_range(4, 0) == 0) begin
          xf_req  = 1'b1;
          xf_side = 1'($urandom_range(1, 0));
        end
      end else if ($urandom_range(29, 0) == 0) begin
        xf_req = 1'b0;
      end
    end
    v1_rand = 1'b0;
    rd_req = 1'b0;
    xf_req = 1'b0;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
